router_reg: RTL and testbench

Datapath register stage of the 1x3 router, directly downstream of the router FSM controller. Consumes the FSM state strobes and produces:
- the byte stream written into the selected output FIFO
- the parity_done and low_packet_valid status the FSM branches on
- the packet error flag

Holds the header byte and the byte stalled during a FIFO-full event, and computes the running XOR parity.

---
 rtl/router_reg.sv | 138 +++++++++++++
 tb/tb_router_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg.sv
`default_nettype none
// router_reg: datapath register stage of the 1x3 router (header/stall holding, XOR parity, error flag).
// Optional macro ROUTER_REG_ERRCNT_EN adds a saturating err_count output.
module router_reg #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          lfd_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          parity_done,
    output logic          low_packet_valid,
    output logic          err
`ifdef ROUTER_REG_ERRCNT_EN
    ,
    output logic [7:0]    err_count
`endif
);

    localparam logic [1:0] c_bad_addr = 2'b11;

    logic [DW-1:0] header_byte;
    logic [DW-1:0] full_byte;
    logic [DW-1:0] int_parity;
    logic [DW-1:0] pkt_parity;

    logic          hdr_load;
    logic          payload_write;
    logic          payload_stall;
    logic          parity_from_bus;
    logic          parity_from_stall;
    logic          err_next;

    always_comb begin
        hdr_load          = detect_add && pkt_valid && (data_in[1:0] != c_bad_addr);
        payload_write     = ld_state && !fifo_full;
        payload_stall     = ld_state && fifo_full;
        parity_from_bus   = ld_state && !fifo_full && !pkt_valid;
        parity_from_stall = laf_state && low_packet_valid && !parity_done;
        err_next          = err;
        if (detect_add) begin
            err_next = 1'b0;
        end else if (parity_done) begin
            err_next = (int_parity != pkt_parity);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_byte <= '0;
        end else if (hdr_load) begin
            header_byte <= data_in;
        end
    end

    // A stalled byte is parked in full_byte and replayed from LOAD_AFTER_FULL.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout      <= '0;
            full_byte <= '0;
        end else if (lfd_state) begin
            dout <= header_byte;
        end else if (payload_write) begin
            dout <= data_in;
        end else if (payload_stall) begin
            full_byte <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    // The parity byte arrives with pkt_valid low and is never folded in.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
        end else if (detect_add) begin
            int_parity <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
            pkt_parity  <= '0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if (parity_from_bus) begin
            parity_done <= 1'b1;
            pkt_parity  <= data_in;
        end else if (parity_from_stall) begin
            parity_done <= 1'b1;
            pkt_parity  <= full_byte;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_packet_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end

`ifdef ROUTER_REG_ERRCNT_EN
    // Counts rising edges of err; only resetn clears it, so it survives packet boundaries.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'h00;
        end else if (!err && err_next && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_reg.sv
`default_nettype none
// tb_router_reg: scoreboard bench for router_reg; expected dout bytes queued at drive time.
module tb_router_reg;

    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_DA   = 5'b10000;
    localparam logic [4:0] S_LFD  = 5'b01000;
    localparam logic [4:0] S_LD   = 5'b00100;
    localparam logic [4:0] S_FS   = 5'b00010;
    localparam logic [4:0] S_LAF  = 5'b00001;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_packet_valid, err;
`ifdef ROUTER_REG_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] sb_q[$];
    logic [7:0] m_header, m_full, m_dout;

    router_reg #(.DW(8)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .lfd_state        (lfd_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
`ifdef ROUTER_REG_ERRCNT_EN
        ,
        .err_count        (err_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock cycle: drive inputs, queue the byte dout must show after the edge, then compare.
    task automatic cyc(input logic [4:0] st, input logic pv, input logic ff,
                       input logic rir, input logic [7:0] d);
        logic [7:0] exp_b;
        {detect_add, lfd_state, ld_state, full_state, laf_state} = st;
        pkt_valid   = pv;
        fifo_full   = ff;
        rst_int_reg = rir;
        data_in     = d;
        if (st == S_LFD) sb_q.push_back(m_header);
        else if (st == S_LD && !ff) sb_q.push_back(d);
        else if (st == S_LAF) sb_q.push_back(m_full);
        if (st == S_LD && ff) m_full = d;
        if (st == S_DA && pv && d[1:0] != 2'b11) m_header = d;
        @(posedge clock);
        #1;
        if (sb_q.size() > 0) begin
            exp_b  = sb_q.pop_front();
            m_dout = exp_b;
        end
        tests++;
        if (dout !== m_dout) begin
            fails++;
            $display("FAIL dout: got %02h want %02h at %0t", dout, m_dout, $time);
        end
    endtask

    task automatic run_packet(input logic [7:0] hdr, input logic [7:0] par, input int stall_at);
        cyc(S_DA, 1'b1, 1'b0, 1'b0, hdr);
        cyc(S_LFD, 1'b1, 1'b0, 1'b0, 8'h01);
        for (int i = 1; i <= 5; i++) begin
            if (i == stall_at) begin
                cyc(S_LD, 1'b1, 1'b1, 1'b0, 8'(i));
                cyc(S_FS, 1'b1, 1'b1, 1'b0, 8'(i));
                cyc(S_LAF, 1'b1, 1'b0, 1'b0, 8'(i));
            end else begin
                cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'(i));
            end
        end
        cyc(S_LD, 1'b0, 1'b0, 1'b0, par);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_header = 8'h00;
        m_full   = 8'h00;
        m_dout   = 8'h00;
    endtask

    task automatic test_reset();
        {detect_add, lfd_state, ld_state, full_state, laf_state} = S_IDLE;
        pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; data_in = 8'h00;
        model_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %02h want 00", dout); end
        tests++; if (parity_done !== 1'b0) begin fails++; $display("FAIL reset_parity_done: got %b want 0", parity_done); end
        tests++; if (low_packet_valid !== 1'b0) begin fails++; $display("FAIL reset_lpv: got %b want 0", low_packet_valid); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
`ifdef ROUTER_REG_ERRCNT_EN
        tests++; if (err_count !== 8'h00) begin fails++; $display("FAIL reset_err_count: got %02h want 00", err_count); end
`endif
        resetn = 1'b1;
        cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_good_packet();
        run_packet(8'h14, 8'h15, -1);
        tests++; if (parity_done !== 1'b1) begin fails++; $display("FAIL good_parity_done: got %b want 1", parity_done); end
        tests++; if (low_packet_valid !== 1'b1) begin fails++; $display("FAIL good_lpv_set: got %b want 1", low_packet_valid); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL good_err: got %b want 0", err); end
        tests++; if (low_packet_valid !== 1'b0) begin fails++; $display("FAIL good_lpv_clear: got %b want 0", low_packet_valid); end
    endtask

    task automatic test_bad_parity();
        run_packet(8'h14, 8'h16, -1);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL bad_err_early: got %b want 0", err); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_err: got %b want 1", err); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL bad_err_hold: got %b want 1", err); end
`ifdef ROUTER_REG_ERRCNT_EN
        tests++; if (err_count !== 8'h01) begin fails++; $display("FAIL bad_err_count: got %02h want 01", err_count); end
`endif
    endtask

    // Also exercises detect_add clearing the error of the previous packet.
    task automatic test_invalid_addr();
        cyc(S_DA, 1'b1, 1'b0, 1'b0, 8'h17);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL inv_err_clear: got %b want 0", err); end
        tests++; if (parity_done !== 1'b0) begin fails++; $display("FAIL inv_parity_done_clear: got %b want 0", parity_done); end
        cyc(S_LFD, 1'b1, 1'b0, 1'b0, 8'h00);
        tests++; if (dout !== 8'h14) begin fails++; $display("FAIL inv_header_kept: got %02h want 14", dout); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef ROUTER_REG_ERRCNT_EN
        tests++; if (err_count !== 8'h01) begin fails++; $display("FAIL inv_err_count_kept: got %02h want 01", err_count); end
`endif
    endtask

    task automatic test_fifo_full_mid();
        run_packet(8'h14, 8'h15, 3);
        tests++; if (parity_done !== 1'b1) begin fails++; $display("FAIL stall_parity_done: got %b want 1", parity_done); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL stall_err: got %b want 0", err); end
    endtask

    task automatic test_full_last_byte();
        cyc(S_DA, 1'b1, 1'b0, 1'b0, 8'h14);
        cyc(S_LFD, 1'b1, 1'b0, 1'b0, 8'h01);
        for (int i = 1; i <= 5; i++) cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'(i));
        cyc(S_LD, 1'b0, 1'b1, 1'b0, 8'h15);
        tests++; if (low_packet_valid !== 1'b1) begin fails++; $display("FAIL last_lpv: got %b want 1", low_packet_valid); end
        tests++; if (parity_done !== 1'b0) begin fails++; $display("FAIL last_parity_done_early: got %b want 0", parity_done); end
        cyc(S_FS, 1'b0, 1'b1, 1'b0, 8'h15);
        cyc(S_LAF, 1'b0, 1'b0, 1'b0, 8'h15);
        tests++; if (parity_done !== 1'b1) begin fails++; $display("FAIL last_parity_done: got %b want 1", parity_done); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (low_packet_valid !== 1'b0) begin fails++; $display("FAIL last_lpv_clear: got %b want 0", low_packet_valid); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL last_err: got %b want 0", err); end
    endtask

    task automatic test_async_reset();
        cyc(S_DA, 1'b1, 1'b0, 1'b0, 8'h14);
        cyc(S_LFD, 1'b1, 1'b0, 1'b0, 8'h01);
        cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'h01);
        cyc(S_LD, 1'b1, 1'b0, 1'b0, 8'h02);
        #2;
        resetn = 1'b0;
        #1;
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL areset_dout: got %02h want 00", dout); end
        tests++; if (parity_done !== 1'b0) begin fails++; $display("FAIL areset_parity_done: got %b want 0", parity_done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL areset_err: got %b want 0", err); end
`ifdef ROUTER_REG_ERRCNT_EN
        tests++; if (err_count !== 8'h00) begin fails++; $display("FAIL areset_err_count: got %02h want 00", err_count); end
`endif
        {detect_add, lfd_state, ld_state, full_state, laf_state} = S_IDLE;
        pkt_valid = 0; fifo_full = 0; rst_int_reg = 0;
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        run_packet(8'h14, 8'h15, -1);
        tests++; if (parity_done !== 1'b1) begin fails++; $display("FAIL areset_pkt_parity_done: got %b want 1", parity_done); end
        cyc(S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL areset_pkt_err: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_invalid_addr();
        test_fifo_full_mid();
        test_full_last_byte();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
